id_ex_hazard_reg: RTL and testbench

ID/EX pipeline register for the pipelined MIPS core, sitting directly downstream of the opcode control decoder. It latches the decoded control bundle plus operand and register-address fields at each clock, and forwards them to the EX stage. It detects load-use hazards against the instruction currently in EX. On a hazard it inserts a one-cycle bubble and asserts a stall to the PC and IF/ID register. It also squashes its contents on a branch flush and keeps saturating counters of bubbles and flushes for debug.

---
 rtl/id_ex_hazard_reg.sv | 181 ++++++++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush
// squash and saturating debug counters for bubbles and flushes.
module id_ex_hazard_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_i,
    input  logic                      reg_dst_i,
    input  logic                      branch_eq_i,
    input  logic                      branch_ne_i,
    input  logic                      mem_read_i,
    input  logic                      mem_to_reg_i,
    input  logic                      mem_write_i,
    input  logic                      alu_src_i,
    input  logic                      reg_write_i,
    input  logic [2:0]                alu_op_i,
    input  logic [5:0]                funct_i,
    input  logic [DATA_WIDTH-1:0]     rs_data_i,
    input  logic [DATA_WIDTH-1:0]     rt_data_i,
    input  logic [DATA_WIDTH-1:0]     imm_i,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rt_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                      flush_i,
    output logic                      reg_dst_o,
    output logic                      branch_eq_o,
    output logic                      branch_ne_o,
    output logic                      mem_read_o,
    output logic                      mem_to_reg_o,
    output logic                      mem_write_o,
    output logic                      alu_src_o,
    output logic                      reg_write_o,
    output logic [2:0]                alu_op_o,
    output logic [5:0]                funct_o,
    output logic [DATA_WIDTH-1:0]     rs_data_o,
    output logic [DATA_WIDTH-1:0]     rt_data_o,
    output logic [DATA_WIDTH-1:0]     imm_o,
    output logic [DATA_WIDTH-1:0]     pc_plus4_o,
    output logic [REG_ADDR_WIDTH-1:0] rs_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rt_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic                      valid_o,
    output logic                      stall_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o,
    output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

    logic                      r_valid;
    logic                      r_reg_dst;
    logic                      r_branch_eq;
    logic                      r_branch_ne;
    logic                      r_mem_read;
    logic                      r_mem_to_reg;
    logic                      r_mem_write;
    logic                      r_alu_src;
    logic                      r_reg_write;
    logic [2:0]                r_alu_op;
    logic [5:0]                r_funct;
    logic [DATA_WIDTH-1:0]     r_rs_data;
    logic [DATA_WIDTH-1:0]     r_rt_data;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic [DATA_WIDTH-1:0]     r_pc_plus4;
    logic [REG_ADDR_WIDTH-1:0] r_rs_addr;
    logic [REG_ADDR_WIDTH-1:0] r_rt_addr;
    logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
    logic [CNT_WIDTH-1:0]      r_stall_cnt;
    logic [CNT_WIDTH-1:0]      r_flush_cnt;

    logic w_hazard;
    logic w_bubble;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Load in EX whose destination (rt) is a source of the ID instruction.
    // Register $zero never creates a dependency.
    always_comb begin
        w_hazard = valid_i & r_valid & r_mem_read &
                   (r_rt_addr != '0) &
                   ((r_rt_addr == rs_addr_i) | (r_rt_addr == rt_addr_i));
        w_bubble = flush_i | w_hazard;
        stall_o  = w_hazard & ~flush_i;
    end

    // Pipeline register: a bubble clears control and valid but keeps data,
    // so the held load's fields stay harmless once valid drops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_branch_eq  <= 1'b0;
            r_branch_ne  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_alu_op     <= '0;
            r_funct      <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_pc_plus4   <= '0;
            r_rs_addr    <= '0;
            r_rt_addr    <= '0;
            r_rd_addr    <= '0;
        end else if (w_bubble) begin
            r_valid      <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_branch_eq  <= 1'b0;
            r_branch_ne  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_alu_op     <= '0;
        end else begin
            r_valid      <= valid_i;
            r_reg_dst    <= reg_dst_i;
            r_branch_eq  <= branch_eq_i;
            r_branch_ne  <= branch_ne_i;
            r_mem_read   <= mem_read_i;
            r_mem_to_reg <= mem_to_reg_i;
            r_mem_write  <= mem_write_i;
            r_alu_src    <= alu_src_i;
            r_reg_write  <= reg_write_i;
            r_alu_op     <= alu_op_i;
            r_funct      <= funct_i;
            r_rs_data    <= rs_data_i;
            r_rt_data    <= rt_data_i;
            r_imm        <= imm_i;
            r_pc_plus4   <= pc_plus4_i;
            r_rs_addr    <= rs_addr_i;
            r_rt_addr    <= rt_addr_i;
            r_rd_addr    <= rd_addr_i;
        end
    end

    // Debug counters: flush takes priority, so a coincident hazard is not counted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (flush_i) begin
            r_flush_cnt <= sat_inc(r_flush_cnt);
        end else if (w_hazard) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign valid_o      = r_valid;
    assign reg_dst_o    = r_reg_dst;
    assign branch_eq_o  = r_branch_eq;
    assign branch_ne_o  = r_branch_ne;
    assign mem_read_o   = r_mem_read;
    assign mem_to_reg_o = r_mem_to_reg;
    assign mem_write_o  = r_mem_write;
    assign alu_src_o    = r_alu_src;
    assign reg_write_o  = r_reg_write;
    assign alu_op_o     = r_alu_op;
    assign funct_o      = r_funct;
    assign rs_data_o    = r_rs_data;
    assign rt_data_o    = r_rt_data;
    assign imm_o        = r_imm;
    assign pc_plus4_o   = r_pc_plus4;
    assign rs_addr_o    = r_rs_addr;
    assign rt_addr_o    = r_rt_addr;
    assign rd_addr_o    = r_rd_addr;
    assign stall_cnt_o  = r_stall_cnt;
    assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: a driver applies directed vectors
// and queues the hand-computed expected EX-side view for each cycle; a monitor
// on the falling edge pops and compares. A second instance with 4-bit counters
// exercises counter saturation within a short run.
module tb_id_ex_hazard_reg;

    typedef struct {
        logic        vld;
        logic [7:0]  ctl;
        logic [2:0]  aop;
        logic [31:0] imm;
        logic [4:0]  rsa;
        logic [4:0]  rta;
        logic        stall;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, flush_i;
    logic [7:0]  ctl_i;
    logic [2:0]  alu_op_i;
    logic [5:0]  funct_i;
    logic [31:0] rs_data_i, rt_data_i, imm_i, pc_plus4_i;
    logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;

    logic        reg_dst_o, branch_eq_o, branch_ne_o, mem_read_o;
    logic        mem_to_reg_o, mem_write_o, alu_src_o, reg_write_o;
    logic [2:0]  alu_op_o;
    logic [5:0]  funct_o;
    logic [31:0] rs_data_o, rt_data_o, imm_o, pc_plus4_o;
    logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
    logic        valid_o, stall_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;
    logic [7:0]  ctl_o;

    logic        s_reg_dst, s_beq, s_bne, s_mr, s_m2r, s_mw, s_asrc, s_rw;
    logic [2:0]  s_aop;
    logic [5:0]  s_funct;
    logic [31:0] s_rsd, s_rtd, s_imm, s_pc;
    logic [4:0]  s_rsa, s_rta, s_rda;
    logic        s_valid, s_stall;
    logic [3:0]  s_sc, s_fc;

    assign ctl_o = {reg_dst_o, branch_eq_o, branch_ne_o, mem_read_o,
                    mem_to_reg_o, mem_write_o, alu_src_o, reg_write_o};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    id_ex_hazard_reg dut (
        .clk(clk), .reset(reset), .valid_i(valid_i),
        .reg_dst_i(ctl_i[7]), .branch_eq_i(ctl_i[6]), .branch_ne_i(ctl_i[5]),
        .mem_read_i(ctl_i[4]), .mem_to_reg_i(ctl_i[3]), .mem_write_i(ctl_i[2]),
        .alu_src_i(ctl_i[1]), .reg_write_i(ctl_i[0]),
        .alu_op_i(alu_op_i), .funct_i(funct_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .pc_plus4_i(pc_plus4_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i),
        .reg_dst_o(reg_dst_o), .branch_eq_o(branch_eq_o), .branch_ne_o(branch_ne_o),
        .mem_read_o(mem_read_o), .mem_to_reg_o(mem_to_reg_o), .mem_write_o(mem_write_o),
        .alu_src_o(alu_src_o), .reg_write_o(reg_write_o),
        .alu_op_o(alu_op_o), .funct_o(funct_o),
        .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o), .pc_plus4_o(pc_plus4_o),
        .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
        .valid_o(valid_o), .stall_o(stall_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    id_ex_hazard_reg #(.CNT_WIDTH(4)) u_sat (
        .clk(clk), .reset(reset), .valid_i(valid_i),
        .reg_dst_i(ctl_i[7]), .branch_eq_i(ctl_i[6]), .branch_ne_i(ctl_i[5]),
        .mem_read_i(ctl_i[4]), .mem_to_reg_i(ctl_i[3]), .mem_write_i(ctl_i[2]),
        .alu_src_i(ctl_i[1]), .reg_write_i(ctl_i[0]),
        .alu_op_i(alu_op_i), .funct_i(funct_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .pc_plus4_i(pc_plus4_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i),
        .reg_dst_o(s_reg_dst), .branch_eq_o(s_beq), .branch_ne_o(s_bne),
        .mem_read_o(s_mr), .mem_to_reg_o(s_m2r), .mem_write_o(s_mw),
        .alu_src_o(s_asrc), .reg_write_o(s_rw),
        .alu_op_o(s_aop), .funct_o(s_funct),
        .rs_data_o(s_rsd), .rt_data_o(s_rtd), .imm_o(s_imm), .pc_plus4_o(s_pc),
        .rs_addr_o(s_rsa), .rt_addr_o(s_rta), .rd_addr_o(s_rda),
        .valid_o(s_valid), .stall_o(s_stall),
        .stall_cnt_o(s_sc), .flush_cnt_o(s_fc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    function automatic logic [31:0] sat4(input logic [15:0] v);
        return (v > 16'd15) ? 32'd15 : {16'd0, v};
    endfunction

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("valid_o",     {31'd0, valid_o},       {31'd0, e.vld});
                chk("ctl_o",       {24'd0, ctl_o},         {24'd0, e.ctl});
                chk("alu_op_o",    {29'd0, alu_op_o},      {29'd0, e.aop});
                chk("imm_o",       imm_o,                  e.imm);
                chk("rs_data_o",   rs_data_o,              e.imm << 1);
                chk("rt_data_o",   rt_data_o,              e.imm << 2);
                chk("pc_plus4_o",  pc_plus4_o,             e.imm << 3);
                chk("funct_o",     {26'd0, funct_o},       {26'd0, e.imm[5:0]});
                chk("rs_addr_o",   {27'd0, rs_addr_o},     {27'd0, e.rsa});
                chk("rt_addr_o",   {27'd0, rt_addr_o},     {27'd0, e.rta});
                chk("rd_addr_o",   {27'd0, rd_addr_o},     {27'd0, 5'(e.rsa + e.rta)});
                chk("stall_o",     {31'd0, stall_o},       {31'd0, e.stall});
                chk("stall_cnt_o", {16'd0, stall_cnt_o},   {16'd0, e.sc});
                chk("flush_cnt_o", {16'd0, flush_cnt_o},   {16'd0, e.fc});
                chk("sat_stall_cnt", {28'd0, s_sc},        sat4(e.sc));
                chk("sat_flush_cnt", {28'd0, s_fc},        sat4(e.fc));
            end
        end
    end

    task automatic apply(input logic r, input logic v, input logic [7:0] c, input logic [2:0] a,
                         input logic [31:0] im, input logic [4:0] rs, input logic [4:0] rt,
                         input logic f);
        reset      = r;
        valid_i    = v;
        ctl_i      = c;
        alu_op_i   = a;
        imm_i      = im;
        rs_data_i  = im << 1;
        rt_data_i  = im << 2;
        pc_plus4_i = im << 3;
        funct_i    = im[5:0];
        rs_addr_i  = rs;
        rt_addr_i  = rt;
        rd_addr_i  = 5'(rs + rt);
        flush_i    = f;
    endtask

    // One cycle: drive ID inputs, queue what EX should show in this cycle.
    task automatic step(input logic r, input logic v, input logic [7:0] c, input logic [2:0] a,
                        input logic [31:0] im, input logic [4:0] rs, input logic [4:0] rt,
                        input logic f,
                        input logic ev, input logic [7:0] ec, input logic [2:0] ea,
                        input logic [31:0] eim, input logic [4:0] ers, input logic [4:0] ert,
                        input logic est, input logic [15:0] esc, input logic [15:0] efc);
        exp_t e;
        @(posedge clk);
        #1;
        apply(r, v, c, a, im, rs, rt, f);
        e.vld = ev; e.ctl = ec; e.aop = ea; e.imm = eim; e.rsa = ers; e.rta = ert;
        e.stall = est; e.sc = esc; e.fc = efc;
        q.push_back(e);
    endtask

    localparam logic [7:0] ADDI = 8'h03;
    localparam logic [7:0] LW   = 8'h1B;
    localparam logic [7:0] RTY  = 8'h81;

    initial begin
        int wait_cyc;
        // Reset held over two edges with random inputs
        apply(1'b0, 1'($urandom), 8'($urandom), 3'($urandom), $urandom,
              5'($urandom), 5'($urandom), 1'($urandom));
        step(1'b0, 1'($urandom), 8'($urandom), 3'($urandom), $urandom,
             5'($urandom), 5'($urandom), 1'($urandom),
             0, 8'h00, 3'd0, 32'h0, 5'd0, 5'd0, 0, 16'd0, 16'd0);
        // addi passes through
        step(1, 1, ADDI, 3'b100, 32'h5, 5'd3, 5'd8, 0,
             0, 8'h00, 3'd0, 32'h0, 5'd0, 5'd0, 0, 16'd0, 16'd0);
        // load rt=8
        step(1, 1, LW, 3'b000, 32'h10, 5'd9, 5'd8, 0,
             1, ADDI, 3'b100, 32'h5, 5'd3, 5'd8, 0, 16'd0, 16'd0);
        // R-type reads rs=8 -> stall
        step(1, 1, RTY, 3'b010, 32'h20, 5'd8, 5'd10, 0,
             1, LW, 3'b000, 32'h10, 5'd9, 5'd8, 1, 16'd0, 16'd0);
        // R-type held, bubble in EX
        step(1, 1, RTY, 3'b010, 32'h20, 5'd8, 5'd10, 0,
             0, 8'h00, 3'd0, 32'h10, 5'd9, 5'd8, 0, 16'd1, 16'd0);
        // R-type reaches EX
        step(1, 1, ADDI, 3'b100, 32'h30, 5'd10, 5'd11, 0,
             1, RTY, 3'b010, 32'h20, 5'd8, 5'd10, 0, 16'd1, 16'd0);
        // load with rt=0 then consumer of $zero
        step(1, 1, LW, 3'b000, 32'h40, 5'd12, 5'd0, 0,
             1, ADDI, 3'b100, 32'h30, 5'd10, 5'd11, 0, 16'd1, 16'd0);
        step(1, 1, RTY, 3'b010, 32'h50, 5'd0, 5'd0, 0,
             1, LW, 3'b000, 32'h40, 5'd12, 5'd0, 0, 16'd1, 16'd0);
        // invalid load rt=8 then consumer rs=8
        step(1, 0, LW, 3'b000, 32'h60, 5'd1, 5'd8, 0,
             1, RTY, 3'b010, 32'h50, 5'd0, 5'd0, 0, 16'd1, 16'd0);
        step(1, 1, RTY, 3'b010, 32'h70, 5'd8, 5'd2, 0,
             0, LW, 3'b000, 32'h60, 5'd1, 5'd8, 0, 16'd1, 16'd0);
        // load rt=7 then consumer via rt=7
        step(1, 1, LW, 3'b000, 32'h80, 5'd4, 5'd7, 0,
             1, RTY, 3'b010, 32'h70, 5'd8, 5'd2, 0, 16'd1, 16'd0);
        step(1, 1, RTY, 3'b010, 32'h90, 5'd5, 5'd7, 0,
             1, LW, 3'b000, 32'h80, 5'd4, 5'd7, 1, 16'd1, 16'd0);
        step(1, 1, RTY, 3'b010, 32'h90, 5'd5, 5'd7, 0,
             0, 8'h00, 3'd0, 32'h80, 5'd4, 5'd7, 0, 16'd2, 16'd0);
        // flush coinciding with a hazard
        step(1, 1, LW, 3'b000, 32'hA0, 5'd6, 5'd9, 0,
             1, RTY, 3'b010, 32'h90, 5'd5, 5'd7, 0, 16'd2, 16'd0);
        step(1, 1, RTY, 3'b010, 32'hB0, 5'd9, 5'd3, 1,
             1, LW, 3'b000, 32'hA0, 5'd6, 5'd9, 0, 16'd2, 16'd0);
        step(1, 1, ADDI, 3'b100, 32'hC0, 5'd1, 5'd2, 0,
             0, 8'h00, 3'd0, 32'hA0, 5'd6, 5'd9, 0, 16'd2, 16'd1);
        // self-dependent load repeated: alternating stall / bubble
        step(1, 1, LW, 3'b000, 32'hD0, 5'd13, 5'd13, 0,
             1, ADDI, 3'b100, 32'hC0, 5'd1, 5'd2, 0, 16'd2, 16'd1);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, LW, 3'b000, 32'hD0, 5'd13, 5'd13, 0,
                 1, LW, 3'b000, 32'hD0, 5'd13, 5'd13, 1, 16'(2 + i), 16'd1);
            step(1, 1, LW, 3'b000, 32'hD0, 5'd13, 5'd13, 0,
                 0, 8'h00, 3'd0, 32'hD0, 5'd13, 5'd13, 0, 16'(3 + i), 16'd1);
        end
        // reset asserted during a stall cycle
        step(0, 1, LW, 3'b000, 32'hD0, 5'd13, 5'd13, 0,
             1, LW, 3'b000, 32'hD0, 5'd13, 5'd13, 1, 16'd18, 16'd1);
        step(1, 1, LW, 3'b000, 32'hD0, 5'd13, 5'd13, 0,
             0, 8'h00, 3'd0, 32'h0, 5'd0, 5'd0, 0, 16'd0, 16'd0);
        step(1, 0, 8'h00, 3'd0, 32'h0, 5'd0, 5'd0, 0,
             1, LW, 3'b000, 32'hD0, 5'd13, 5'd13, 0, 16'd0, 16'd0);
        step(1, 0, 8'h00, 3'd0, 32'h0, 5'd0, 5'd0, 0,
             0, 8'h00, 3'd0, 32'h0, 5'd0, 5'd0, 0, 16'd0, 16'd0);

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
